// File: rtl/ext_stream.sv
// Immediate extender with a DEPTH-entry output FIFO and valid/ready handshakes on both sides.
// Results are extended at push time, so the FIFO stores extended values rather than raw immediates.
module ext_stream #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            imm,
    input  logic [1:0]                 EOp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           ext,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic [OUT_W-1:0] sext, zext, upper, ext_val;
    logic             push, pop;

    assign sext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign zext  = {{(OUT_W-IN_W){1'b0}}, imm};
    assign upper = {imm, {(OUT_W-IN_W){1'b0}}};

    always_comb begin
        ext_val = '0;
        unique case (EOp)
            2'd0: ext_val = sext;
            2'd1: ext_val = zext;
            2'd2: ext_val = upper;
            2'd3: ext_val = sext << 2;
            default: ext_val = '0;
        endcase
    end

    // Flags come from registered count only, so in_ready never depends on out_ready.
    assign in_ready  = (count_q != CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign ext       = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= ext_val;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_ext_stream.sv
// Self-checking bench for ext_stream: vector table, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_ext_stream;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [1:0]  eop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mq[$];

    always #5 clk = ~clk;

    ext_stream #(
        .IN_W (16),
        .OUT_W(32),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .imm      (imm),
        .EOp      (eop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ext      (ext),
        .count    (count)
    );

    function automatic logic [31:0] model_ext(input logic [15:0] v, input logic [1:0] op);
        int s;
        s = int'($signed(v));
        case (op)
            2'd0:    return 32'(s);
            2'd1:    return 32'(v);
            2'd2:    return 32'(v) * 32'd65536;
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        chk("model_count", 32'(count), 32'(n));
        chk("model_out_valid", 32'(out_valid), 32'(n != 0));
        chk("model_in_ready", 32'(in_ready), 32'(n != DEPTH));
        chk("model_ext", ext, (n != 0) ? mq[0] : 32'h0);
    endtask

    // Drive one cycle of inputs, advance the model and check the DUT after the edge.
    task automatic cycle(input logic v, input logic [15:0] i, input logic [1:0] op,
                         input logic ordy, input logic rn, output logic pushed);
        logic do_push, do_pop;
        in_valid  = v;
        imm       = i;
        eop       = op;
        out_ready = ordy;
        reset     = rn;
        do_push   = rn && v && (mq.size() != DEPTH);
        do_pop    = rn && ordy && (mq.size() != 0);
        @(posedge clk);
        #1;
        if (!rn) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(model_ext(i, op));
        end
        pushed = do_push;
        check_model();
    endtask

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic        p;
        logic        item5_in;
        logic [31:0] got[$];
        int          k;

        vt[0] = '{16'hfabc, 2'd0, 32'hfffffabc};
        vt[1] = '{16'hfabc, 2'd1, 32'h0000fabc};
        vt[2] = '{16'hfabc, 2'd2, 32'hfabc0000};
        vt[3] = '{16'hfabc, 2'd3, 32'hffffeaf0};
        vt[4] = '{16'h7abc, 2'd0, 32'h00007abc};
        vt[5] = '{16'h7abc, 2'd3, 32'h0001eaf0};
        vt[6] = '{16'h8000, 2'd2, 32'h80000000};
        vt[7] = '{16'hffff, 2'd1, 32'h0000ffff};

        // Reset state
        cycle(1'b0, 16'h0, 2'd0, 1'b0, 1'b0, p);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_ext", ext, 32'h0);

        // Vector table: one push, visible the cycle after, then popped
        for (int j = 0; j < 8; j++) begin
            cycle(1'b1, vt[j].imm, vt[j].op, 1'b1, 1'b1, p);
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_ext", ext, vt[j].exp);
            cycle(1'b0, 16'h0, 2'd0, 1'b1, 1'b1, p);
            chk("vec_drained", 32'(count), 32'd0);
        end

        // Fill to full with out_ready low; 5th item must be held
        for (int j = 1; j <= 4; j++) cycle(1'b1, 16'(j), 2'd1, 1'b0, 1'b1, p);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 16'd5, 2'd1, 1'b0, 1'b1, p);
        chk("full_hold_count", 32'(count), 32'd4);
        chk("full_hold_nopush", 32'(p), 32'd0);
        item5_in = 1'b0;
        k = 0;
        while (k < 12 && (out_valid || !item5_in)) begin
            if (out_valid) got.push_back(ext);
            cycle(!item5_in, 16'd5, 2'd1, 1'b1, 1'b1, p);
            if (p) item5_in = 1'b1;
            k++;
        end
        chk("drain_len", 32'(got.size()), 32'd5);
        for (int j = 0; j < 5; j++) begin
            chk("drain_order", (j < got.size()) ? got[j] : 32'hdeadbeef, 32'(j + 1));
        end
        chk("drain_count", 32'(count), 32'd0);

        // Continuous streaming across pointer wrap
        for (int j = 0; j < 10; j++) begin
            cycle(1'b1, 16'(100 + j), 2'd1, 1'b1, 1'b1, p);
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_ext", ext, 32'(100 + j));
        end
        cycle(1'b0, 16'h0, 2'd0, 1'b1, 1'b1, p);
        chk("stream_empty", 32'(count), 32'd0);

        // Reset with entries buffered and a push offered
        for (int j = 0; j < 3; j++) cycle(1'b1, 16'(j + 7), 2'd0, 1'b0, 1'b1, p);
        chk("pre_reset_count", 32'(count), 32'd3);
        cycle(1'b1, 16'h1234, 2'd0, 1'b1, 1'b0, p);
        chk("mid_reset_count", 32'(count), 32'd0);
        chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_ext", ext, 32'h0);
        chk("mid_reset_in_ready", 32'(in_ready), 32'd1);
        cycle(1'b0, 16'h0, 2'd0, 1'b0, 1'b1, p);
        chk("post_reset_count", 32'(count), 32'd0);

        // Empty FIFO ignores out_ready
        for (int j = 0; j < 3; j++) begin
            cycle(1'b0, 16'hffff, 2'd3, 1'b1, 1'b1, p);
            chk("empty_count", 32'(count), 32'd0);
            chk("empty_out_valid", 32'(out_valid), 32'd0);
        end

        // Random traffic against the model
        for (int j = 0; j < 600; j++) begin
            cycle(1'($urandom_range(0, 2) != 0), 16'($urandom), 2'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) != 0), p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
